trace_capture_buffer: RTL

//  On-chip, parametrised trace buffer for the RV32IM pipeline. Captures up to CHANNELS

---
 rtl/trace_capture_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/trace_capture_buffer.sv
// Pipeline trace buffer: captures CHANNELS probe words per advancing cycle into a
// circular RAM, stops POST_TRIG samples after a masked channel-0 match, reads out oldest-first.

module trace_lane_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  // Storage is deliberately unreset so it maps onto plain RAM.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;

  assign rdata = mem_q[raddr];
endmodule

module trace_capture_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 64,
  parameter int POST_TRIG  = 16,
  parameter int AW         = $clog2(DEPTH),
  parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [CHANNELS*DATA_WIDTH-1:0] CH_DATA,
  input  logic                           VALID,
  input  logic                           ARM,
  input  logic [DATA_WIDTH-1:0]          TRIG_VALUE,
  input  logic [DATA_WIDTH-1:0]          TRIG_MASK,
  input  logic [AW-1:0]                  RD_ADDR,
  input  logic [CW-1:0]                  RD_CH,
  output logic [DATA_WIDTH-1:0]          RD_DATA,
  output logic [1:0]                     STATE,
  output logic                           DONE,
  output logic                           WRAPPED,
  output logic [AW:0]                    FILL_COUNT,
  output logic [AW-1:0]                  TRIG_POS
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic                  wrapped_q, wrapped_d;
  logic [AW-1:0]         post_q, post_d;
  logic [AW-1:0]         trig_pos_q, trig_pos_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  wr_en, match;
  logic [AW-1:0]         rd_phys;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] lane_rd;

  assign match   = VALID && ((CH_DATA[DATA_WIDTH-1:0] & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK));
  // Once wrapped, the oldest sample sits at the write pointer.
  assign rd_phys = wrapped_q ? (wr_ptr_q + RD_ADDR) : RD_ADDR;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    trace_lane_ram #(.DW(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (CLK),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (CH_DATA[k*DATA_WIDTH +: DATA_WIDTH]),
      .raddr (rd_phys),
      .rdata (lane_rd[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    wrapped_d  = wrapped_q;
    post_d     = post_q;
    trig_pos_d = trig_pos_q;
    wr_en      = 1'b0;

    if (ARM) begin
      state_d   = S_ARMED;
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
      post_d    = '0;
    end else begin
      unique case (state_q)
        S_ARMED: if (VALID) begin
          wr_en = 1'b1;
          if (match) begin
            post_d  = AW'(POST_TRIG);
            state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: if (VALID) begin
          wr_en  = 1'b1;
          post_d = post_q - 1'b1;
          if (post_q == AW'(1)) state_d = S_DONE;
        end
        default: ;
      endcase
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == AW'(DEPTH-1)) wrapped_d = 1'b1;
      if (fill_q != (AW+1)'(DEPTH)) fill_d = fill_q + 1'b1;
    end

    if (state_d == S_DONE && state_q != S_DONE)
      trig_pos_d = AW'(fill_d - (AW+1)'(1) - (AW+1)'(POST_TRIG));

    rd_data_d = '0;
    if (({1'b0, RD_ADDR} < fill_q) && ({1'b0, RD_CH} < (CW+1)'(CHANNELS)))
      rd_data_d = lane_rd[RD_CH];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      wrapped_q  <= 1'b0;
      post_q     <= '0;
      trig_pos_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      wrapped_q  <= wrapped_d;
      post_q     <= post_d;
      trig_pos_q <= trig_pos_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign STATE      = state_q;
  assign DONE       = (state_q == S_DONE);
  assign WRAPPED    = wrapped_q;
  assign FILL_COUNT = fill_q;
  assign TRIG_POS   = trig_pos_q;
  assign RD_DATA    = rd_data_q;
endmodule
